// File: rtl/i2c_burst_datapath.sv
// I2C master burst engine: START, address, data bytes, STOP from one command, with TX/RX byte FIFOs.
// Latency: a burst of N bytes takes 12 + 9N SCL periods from command accept to the done pulse.
// Backpressure: cmd_ready holds until the FIFOs can serve the whole burst; tx_ready=0 when TX is full.

// Byte FIFO with first-word fall-through head and a multi-entry pop for discarding a burst tail.
// Latency: one falling edge from push to head/count update.
// Backpressure: push is dropped while full; pop_n must not exceed count.
module i2c_burst_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic [CW-1:0] pop_n,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;

   assign push_ok = push && (count != CW'(DEPTH));
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(negedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr + AW'(pop_n);
         count  <= count + CW'(push_ok) - pop_n;
      end
   end
endmodule

module i2c_burst_datapath #(
   parameter int DEPTH      = 4,
   parameter int LEN_W      = $clog2(DEPTH + 1),
   parameter bit NACK_ABORT = 1'b1
) (
   input  logic             i2c_scl_in,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [6:0]       cmd_addr,
   input  logic             cmd_rw,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   input  logic             rx_ready,
   input  logic             SDA_in,
   output logic             SDA_out,
   output logic             busy,
   output logic             done,
   output logic             nack_err
);
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA,
      S_WR_ACK, S_RD_DATA, S_RD_ACK, S_STOP_LO, S_STOP_HI
   } state_t;

   state_t           state, state_nx;
   logic [2:0]       bit_cnt, bit_cnt_nx;
   logic [LEN_W-1:0] rem, rem_nx;
   logic [7:0]       addr_rw, addr_rw_nx;
   logic [7:0]       shift, shift_nx;
   logic             nack_nx, done_nx;
   logic [LEN_W-1:0] tx_pop_n, tx_cnt, rx_cnt;
   logic [7:0]       tx_head;
   logic             rx_push;

   i2c_burst_fifo #(.DEPTH(DEPTH), .W(8), .CW(LEN_W)) u_tx_fifo (
      .clk      (i2c_scl_in),
      .reset    (reset),
      .push     (tx_valid),
      .push_dat (tx_data),
      .pop_n    (tx_pop_n),
      .head     (tx_head),
      .count    (tx_cnt)
   );

   i2c_burst_fifo #(.DEPTH(DEPTH), .W(8), .CW(LEN_W)) u_rx_fifo (
      .clk      (i2c_scl_in),
      .reset    (reset),
      .push     (rx_push),
      .push_dat (shift_nx),
      .pop_n    (LEN_W'(rx_valid && rx_ready)),
      .head     (rx_data),
      .count    (rx_cnt)
   );

   assign tx_ready = (tx_cnt != LEN_W'(DEPTH));
   assign rx_valid = (rx_cnt != '0);
   assign busy     = (state != S_IDLE);
   // Reads reserve RX space up front so the burst can never overflow it.
   assign cmd_ready = (state == S_IDLE) &&
                      (cmd_rw ? ((LEN_W'(DEPTH) - rx_cnt) >= cmd_len) : (tx_cnt >= cmd_len));

   // State and datapath registers, all advanced on the SCL falling edge.
   always_ff @(negedge i2c_scl_in or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         bit_cnt  <= 3'd7;
         rem      <= '0;
         addr_rw  <= '0;
         shift    <= '0;
         nack_err <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         bit_cnt  <= bit_cnt_nx;
         rem      <= rem_nx;
         addr_rw  <= addr_rw_nx;
         shift    <= shift_nx;
         nack_err <= nack_nx;
         done     <= done_nx;
      end
   end

   // Sequencer: each transition is the edge that closes one bit period and opens the next.
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      rem_nx     = rem;
      addr_rw_nx = addr_rw;
      shift_nx   = shift;
      nack_nx    = nack_err;
      done_nx    = 1'b0;
      tx_pop_n   = '0;
      rx_push    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_rw_nx = {cmd_addr, cmd_rw};
               rem_nx     = cmd_len;
               nack_nx    = 1'b0;
               state_nx   = S_START;
            end
         end
         S_START: begin
            bit_cnt_nx = 3'd7;
            state_nx   = S_ADDR;
         end
         S_ADDR: begin
            if (bit_cnt == 3'd0) state_nx = S_ADDR_ACK;
            else                 bit_cnt_nx = bit_cnt - 3'd1;
         end
         S_ADDR_ACK: begin
            bit_cnt_nx = 3'd7;
            if (SDA_in) begin
               nack_nx  = 1'b1;
               state_nx = S_STOP_LO;
            end else if (rem == '0) begin
               state_nx = S_STOP_LO;
            end else if (addr_rw[0]) begin
               state_nx = S_RD_DATA;
            end else begin
               shift_nx = tx_head;
               tx_pop_n = LEN_W'(1);
               state_nx = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            if (bit_cnt == 3'd0) state_nx = S_WR_ACK;
            else                 bit_cnt_nx = bit_cnt - 3'd1;
         end
         S_WR_ACK: begin
            bit_cnt_nx = 3'd7;
            if (SDA_in) nack_nx = 1'b1;
            if (SDA_in && NACK_ABORT) begin
               // Drop the unsent tail of this burst so TX is left clean for the next command.
               tx_pop_n = rem - LEN_W'(1);
               state_nx = S_STOP_LO;
            end else begin
               rem_nx = rem - LEN_W'(1);
               if (rem > LEN_W'(1)) begin
                  shift_nx = tx_head;
                  tx_pop_n = LEN_W'(1);
                  state_nx = S_WR_DATA;
               end else begin
                  state_nx = S_STOP_LO;
               end
            end
         end
         S_RD_DATA: begin
            shift_nx = {shift[6:0], SDA_in};
            if (bit_cnt == 3'd0) begin
               rx_push  = 1'b1;
               state_nx = S_RD_ACK;
            end else begin
               bit_cnt_nx = bit_cnt - 3'd1;
            end
         end
         S_RD_ACK: begin
            bit_cnt_nx = 3'd7;
            rem_nx     = rem - LEN_W'(1);
            state_nx   = (rem > LEN_W'(1)) ? S_RD_DATA : S_STOP_LO;
         end
         S_STOP_LO: state_nx = S_STOP_HI;
         S_STOP_HI: begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Bus drive for the current period; 1 releases the open-drain line.
   always_comb begin
      SDA_out = 1'b1;
      case (state)
         S_START, S_STOP_LO: SDA_out = 1'b0;
         S_ADDR:             SDA_out = addr_rw[bit_cnt];
         S_WR_DATA:          SDA_out = shift[bit_cnt];
         S_RD_ACK:           SDA_out = !(rem > LEN_W'(1));
         default:            SDA_out = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_i2c_burst_datapath.sv
module tb_i2c_burst_datapath;
   localparam int DEPTH = 4;
   localparam int LEN_W = $clog2(DEPTH + 1);

   logic             scl = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic [6:0]       cmd_addr;
   logic             cmd_rw;
   logic [LEN_W-1:0] cmd_len;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             rx_ready;
   logic             sda_in;
   logic             sel;

   logic cmd_ready_a, tx_ready_a, rx_valid_a, sda_out_a, busy_a, done_a, nack_a;
   logic cmd_ready_b, tx_ready_b, rx_valid_b, sda_out_b, busy_b, done_b, nack_b;
   logic [7:0] rx_data_a, rx_data_b;
   logic cmd_ready, tx_ready, rx_valid, sda_out, busy, done, nack_err;
   logic [7:0] rx_data;

   int checks = 0;
   int errors = 0;

   bit         exp_sda[$];
   int         exp_periods[$];
   logic [7:0] exp_rx[$];
   logic [7:0] tx_model[$];

   always #10 scl = ~scl;

   // Instance a aborts on a data NACK, instance b carries on; sel picks the one under test.
   i2c_burst_datapath #(.DEPTH(DEPTH), .NACK_ABORT(1'b1)) dut_a (
      .i2c_scl_in(scl), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
      .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
      .rx_ready(rx_ready), .SDA_in(sda_in), .SDA_out(sda_out_a), .busy(busy_a),
      .done(done_a), .nack_err(nack_a));

   i2c_burst_datapath #(.DEPTH(DEPTH), .NACK_ABORT(1'b0)) dut_b (
      .i2c_scl_in(scl), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
      .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
      .rx_ready(rx_ready), .SDA_in(sda_in), .SDA_out(sda_out_b), .busy(busy_b),
      .done(done_b), .nack_err(nack_b));

   assign cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
   assign tx_ready  = sel ? tx_ready_b  : tx_ready_a;
   assign rx_valid  = sel ? rx_valid_b  : rx_valid_a;
   assign rx_data   = sel ? rx_data_b   : rx_data_a;
   assign sda_out   = sel ? sda_out_b   : sda_out_a;
   assign busy      = sel ? busy_b      : busy_a;
   assign done      = sel ? done_b      : done_a;
   assign nack_err  = sel ? nack_b      : nack_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Largest write length the DUT would accept right now, i.e. its TX occupancy.
   task automatic tx_count(output int n);
      n = -1;
      cmd_rw = 1'b0;
      for (int l = DEPTH; l >= 0; l--) begin
         cmd_len = LEN_W'(l);
         #1;
         if (cmd_ready && n < 0) n = l;
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      @(posedge scl);
      #1 check("tx_ready", 32'(tx_ready), 32'(tx_model.size() < DEPTH));
      tx_valid = 1'b1;
      tx_data  = d;
      if (tx_model.size() < DEPTH) tx_model.push_back(d);
      @(negedge scl);
      #1 tx_valid = 1'b0;
   endtask

   task automatic gate_check(input logic rw, input int len);
      @(posedge scl);
      cmd_addr  = 7'h11;
      cmd_rw    = rw;
      cmd_len   = LEN_W'(len);
      cmd_valid = 1'b1;
      #1 check("gate_cmd_ready", 32'(cmd_ready), 32'(rw ? (len <= DEPTH) : (tx_model.size() >= len)));
      repeat (2) @(negedge scl);
      #1 check("gate_busy", 32'(busy), 32'(0));
      cmd_valid = 1'b0;
   endtask

   // Reference model: the bus bit of every period and the slave response, built byte by byte.
   task automatic run_cmd(input logic [6:0] addr, input logic rw, input int len, input bit addr_ack,
                          input logic [DEPTH-1:0] dack, input logic [31:0] rdat, input int abort_at);
      bit         bits[$];
      bit         drv[$];
      logic [7:0] ab, by;
      bit         exp_nack, abort_mode, exp_rdy;
      int         n;
      abort_mode = !sel;
      exp_rdy    = rw ? (len <= DEPTH) : (tx_model.size() >= len);
      ab         = {addr, rw};
      bits.push_back(1'b0); drv.push_back(1'b1);
      for (int i = 7; i >= 0; i--) begin bits.push_back(ab[i]); drv.push_back(1'b1); end
      bits.push_back(1'b1); drv.push_back(!addr_ack);
      exp_nack = !addr_ack;
      if (addr_ack) begin
         for (int b = 0; b < len; b++) begin
            if (!rw) begin
               by = tx_model.pop_front();
               for (int i = 7; i >= 0; i--) begin bits.push_back(by[i]); drv.push_back(1'b1); end
               bits.push_back(1'b1); drv.push_back(!dack[b]);
               if (!dack[b]) begin
                  exp_nack = 1'b1;
                  if (abort_mode) begin
                     for (int d = 0; d < len - 1 - b; d++) by = tx_model.pop_front();
                     break;
                  end
               end
            end else begin
               by = rdat[8*b +: 8];
               exp_rx.push_back(by);
               for (int i = 7; i >= 0; i--) begin bits.push_back(1'b1); drv.push_back(by[i]); end
               bits.push_back(b == len - 1); drv.push_back(1'b1);
            end
         end
      end
      bits.push_back(1'b0); drv.push_back(1'b1);
      bits.push_back(1'b1); drv.push_back(1'b1);

      @(posedge scl);
      cmd_addr  = addr;
      cmd_rw    = rw;
      cmd_len   = LEN_W'(len);
      cmd_valid = 1'b1;
      foreach (bits[i]) exp_sda.push_back(bits[i]);
      exp_periods.push_back(bits.size());
      #1 check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
      @(negedge scl);
      for (int k = 0; k < drv.size(); k++) begin
         @(posedge scl);
         cmd_valid = 1'b0;
         if (k == abort_at) begin
            #2 reset = 1'b1;
            #1;
            check("rst_sda_out", 32'(sda_out), 32'(1));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_nack", 32'(nack_err), 32'(0));
            check("rst_rx_valid", 32'(rx_valid), 32'(0));
            exp_sda.delete(); exp_periods.delete(); exp_rx.delete(); tx_model.delete();
            tx_count(n);
            check("rst_tx_count", 32'(n), 32'(0));
            @(posedge scl);
            #2 reset = 1'b0;
            return;
         end
         sda_in = drv[k];
         @(negedge scl);
      end
      @(posedge scl);
      sda_in = 1'b1;
      #1 check("nack_err", 32'(nack_err), 32'(exp_nack));
      tx_count(n);
      check("tx_count", 32'(n), 32'(tx_model.size()));
   endtask

   // Bus monitor: one expected bit per busy period, and the period count when done pulses.
   initial begin : sda_monitor
      bit prev_busy;
      int pcnt;
      prev_busy = 1'b0;
      pcnt      = 0;
      forever begin
         @(posedge scl);
         if (reset) begin
            prev_busy = 1'b0;
            pcnt      = 0;
            continue;
         end
         if (busy) begin
            if (exp_sda.size() == 0) flag("busy_unexpected");
            else check("sda_out", 32'(sda_out), 32'(exp_sda.pop_front()));
            pcnt++;
         end
         if (prev_busy && !busy) begin
            check("done_pulse", 32'(done), 32'(1));
            if (exp_periods.size() == 0) flag("done_unexpected");
            else check("burst_edges", 32'(pcnt), 32'(exp_periods.pop_front()));
            pcnt = 0;
         end else if (done) begin
            flag("done_spurious");
         end
         prev_busy = busy;
      end
   end

   // RX drain: pops every byte the DUT offers and matches it against the model order.
   initial begin : rx_monitor
      rx_ready = 1'b0;
      forever begin
         @(posedge scl);
         if (!reset && rx_valid) begin
            if (exp_rx.size() == 0) flag("rx_unexpected");
            else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            rx_ready = 1'b1;
         end else begin
            rx_ready = 1'b0;
         end
      end
   end

   logic [DEPTH-1:0] dack;
   logic             rw;
   int               len, np, n;

   task automatic random_round(input int iters);
      for (int it = 0; it < iters; it++) begin
         np = $urandom_range(0, DEPTH + 1);
         for (int j = 0; j < np; j++) push_tx(8'($urandom));
         rw = 1'($urandom_range(0, 1));
         if (!rw) len = $urandom_range(0, tx_model.size());
         else     len = $urandom_range(0, DEPTH);
         if (!rw && tx_model.size() < DEPTH && $urandom_range(0, 3) == 0)
            gate_check(1'b0, tx_model.size() + 1);
         for (int d = 0; d < DEPTH; d++) dack[d] = ($urandom_range(0, 3) != 0);
         run_cmd(7'($urandom), rw, len, $urandom_range(0, 4) != 0, dack, $urandom, -1);
      end
   endtask

   initial begin
      sel = 1'b0; reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0;
      cmd_len = '0; tx_valid = 1'b0; tx_data = '0; sda_in = 1'b1;
      repeat (2) @(posedge scl);
      #1;
      check("reset_sda_out", 32'(sda_out), 32'(1));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_done", 32'(done), 32'(0));
      check("reset_nack", 32'(nack_err), 32'(0));
      check("reset_tx_ready", 32'(tx_ready), 32'(1));
      check("reset_rx_valid", 32'(rx_valid), 32'(0));
      tx_count(n);
      check("reset_tx_count", 32'(n), 32'(0));
      #2 reset = 1'b0;

      // Two-byte write, all slots acknowledged.
      push_tx(8'hA5); push_tx(8'h3C);
      run_cmd(7'h50, 1'b0, 2, 1'b1, '1, 32'h0, -1);
      // Two-byte read returning 0x12 then 0x34.
      run_cmd(7'h68, 1'b1, 2, 1'b1, '1, 32'h0000_3412, -1);
      // Address NACK leaves the queued byte untouched.
      push_tx(8'h77);
      run_cmd(7'h2A, 1'b0, 1, 1'b0, '1, 32'h0, -1);
      // Not enough TX bytes for the requested length.
      gate_check(1'b0, 2);
      // Zero-length probe clears the sticky flag.
      run_cmd(7'h3C, 1'b0, 0, 1'b1, '1, 32'h0, -1);
      // Data NACK on the first byte discards the rest.
      push_tx(8'h81); push_tx(8'h42);
      run_cmd(7'h45, 1'b0, 3, 1'b1, 4'b1110, 32'h0, -1);
      // Reset during address bit 4, then a normal burst.
      push_tx(8'hC3); push_tx(8'h5A); push_tx(8'h0F);
      run_cmd(7'h5A, 1'b0, 2, 1'b1, '1, 32'h0, 4);
      push_tx(8'hDE); push_tx(8'hAD);
      run_cmd(7'h33, 1'b0, 2, 1'b1, '1, 32'h0, -1);
      // Full-depth read and full-depth write.
      run_cmd(7'h7F, 1'b1, DEPTH, 1'b1, '1, 32'hF00D_BEEF, -1);
      for (int j = 0; j < DEPTH + 1; j++) push_tx(8'(j + 8'h90));
      run_cmd(7'h01, 1'b0, DEPTH, 1'b1, '1, 32'h0, -1);
      random_round(15);

      // Switch to the instance that keeps going after a data NACK.
      @(posedge scl);
      #2 reset = 1'b1;
      sel = 1'b1;
      exp_sda.delete(); exp_periods.delete(); exp_rx.delete(); tx_model.delete();
      @(posedge scl);
      #2 reset = 1'b0;
      push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
      run_cmd(7'h45, 1'b0, 3, 1'b1, 4'b1110, 32'h0, -1);
      random_round(15);

      repeat (4) @(posedge scl);
      #1;
      check("sda_queue_empty", 32'(exp_sda.size()), 32'(0));
      check("burst_queue_empty", 32'(exp_periods.size()), 32'(0));
      check("rx_queue_empty", 32'(exp_rx.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_burst_datapath.md
Name: i2c_burst_datapath

Overview:
Master-side I2C bit datapath with its own sequencer. It runs multi-byte write or read bursts from a single command. TX and RX byte FIFOs sit between the host logic and the bus. A command of address, rw and length runs START, address, ACK, data bytes and STOP autonomously, and reports ACK failures. It sits between the host register interface and the open-drain SDA pad logic and replaces the externally sequenced datapath.

Parameters:
DEPTH, 4, TX and RX FIFO depth in bytes (power of 2, >=2); also the maximum burst length.
LEN_W, $clog2(DEPTH+1), derived; width of cmd_len.
NACK_ABORT, 1, 1 = a data-byte NACK ends the burst; 0 = flag it and continue.

Ports:
i2c_scl_in  input  1  block clock; all state updates on its falling edge
reset  input  1  asynchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at an edge
cmd_addr  input  7  7-bit slave address
cmd_rw  input  1  0 = write, 1 = read
cmd_len  input  LEN_W  byte count, 0..DEPTH
tx_valid  input  1  TX byte offered
tx_data  input  8  TX byte
tx_ready  output  1  TX FIFO not full
rx_valid  output  1  RX FIFO not empty
rx_data  output  8  RX FIFO head (first-word fall-through)
rx_ready  input  1  pop RX head
SDA_in  input  1  sampled bus data
SDA_out  output  1  driven bus data (1 = released)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on return to IDLE
nack_err  output  1  sticky ACK-failure flag

Behaviour:
- Reset (async, any time, including mid-burst): state=IDLE, SDA_out=1, busy=0, done=0, nack_err=0, both FIFOs empty, bit counter=7.
- Bit timing: one bit per SCL period.
  - SDA_out is updated at the falling edge that opens a period.
  - SDA_in is sampled at the falling edge that closes that period.
- States: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP_LO, STOP_HI.
- IDLE: SDA_out=1.
  - cmd_ready = (state==IDLE) && (cmd_rw ? RX free >= cmd_len : TX count >= cmd_len).
  - On accept: latch {cmd_addr,cmd_rw} and cmd_len, clear nack_err, go to START.
- START (1 period): SDA_out=0.
- ADDR (8 periods): drive {addr,rw}, MSB first, counter 7..0.
- ADDR_ACK (1 period): SDA_out=1, then sample SDA_in.
  - SDA_in=1: set nack_err, go to STOP_LO.
  - SDA_in=0 with len==0: go to STOP_LO (address probe).
  - Otherwise: go to WR_DATA or RD_DATA.
- WR_DATA (8 periods): pop the TX head at the opening edge, then drive it MSB first.
- WR_ACK (1 period): SDA_out=1, then sample SDA_in.
  - ACK: decrement remaining; if more remain go to WR_DATA, else STOP_LO.
  - NACK: set nack_err.
    - NACK_ABORT=1: discard the rest of this command's bytes from TX (remaining-1 pops in one edge), go to STOP_LO.
    - NACK_ABORT=0: treat as ACK.
- RD_DATA (8 periods): SDA_out=1; shift SDA_in MSB first.
- RD_ACK (1 period):
  - At the opening edge, push the assembled byte to RX.
  - Drive 0 if more bytes remain, else 1 (master NACK on last byte).
- STOP_LO (1 period): SDA_out=0.
- STOP_HI (1 period): SDA_out=1; pulse done at the closing edge, go to IDLE.
- Edge counts (opening edge of START through the closing edge of STOP_HI):
  - burst of N bytes: 12 + 9N edges;
  - probe or address NACK: 12 edges.
- FIFOs:
  - Push and pop in the same edge are allowed.
  - tx_valid while full is ignored (tx_ready=0).
  - RX cannot overflow because space is reserved at command accept.
  - rx_ready while empty is ignored.
- cmd_valid while busy: held off by cmd_ready=0; no queueing.

Test Plan:
- Write: push A5,3C; cmd addr=0x50 rw=0 len=2; bench ACKs every slot.
  - SDA_out = 0, 1010000 0, 1, 10100101, 1, 00111100, 1, 0, 1.
  - done after 30 edges; TX empty; nack_err=0.
- Read: cmd addr=0x68 rw=1 len=2; bench ACKs the address and drives 0x12, 0x34.
  - Master ACK slots: 0 then 1.
  - rx_data pops 12 then 34; 30 edges.
- Address NACK: SDA_in held 1; cmd write len=1 with one byte queued.
  - nack_err=1, STOP after ADDR_ACK, done at edge 12.
  - TX count still 1.
- Data NACK: NACK_ABORT=1, three bytes queued, len=3; NACK on byte 1.
  - TX empty, nack_err=1, done at edge 21.
  - Repeat with NACK_ABORT=0: all 3 bytes sent, 39 edges, nack_err=1.
- Gating and probe:
  - One TX byte queued, write len=2: cmd_ready=0.
  - len=0 probe with ACK: 12 edges, nack_err=0.
- Reset mid-burst: assert reset during ADDR bit 4.
  - Immediately SDA_out=1, busy=0, FIFOs empty.
  - The next command runs normally.
